// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: self-timed UART transmitter with a small transmit FIFO and divide-by-OVERSAMPLE bit timing
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load,
    input  logic [DATA_W-1:0]            dataIn,
    output logic                         ready,
    output logic                         serialOut,
    output logic                         txEmpty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int DIV_W = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state;
    logic [DIV_W-1:0]  divider;
    logic [BIT_W-1:0]  bitCount;
    logic [DATA_W-1:0] shiftReg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              bitDone;
    logic              stopDone;
    logic              push;
    logic              pop;

    assign bitDone  = divider == DIV_W'(OVERSAMPLE - 1);
    assign stopDone = state == STOP && bitDone && bitCount == BIT_W'(STOP_BITS - 1);
    assign ready    = level != LVL_W'(DEPTH);
    assign push     = load && ready;
    assign pop      = level != '0 && (state == IDLE || stopDone);
    assign txEmpty  = state == IDLE && level == '0;

    // FIFO storage; contents are don't-care until the write pointer covers them
    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= dataIn;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            wrPtr <= wrPtr + PTR_W'(push);
            rdPtr <= rdPtr + PTR_W'(pop);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Frame sequencer; serialOut is updated together with the state it belongs to
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            divider   <= '0;
            bitCount  <= '0;
            shiftReg  <= '0;
            serialOut <= 1'b1;
        end else if (pop) begin
            state     <= START;
            divider   <= '0;
            bitCount  <= '0;
            shiftReg  <= mem[rdPtr];
            serialOut <= 1'b0;
        end else begin
            divider <= (state == IDLE || bitDone) ? '0 : divider + DIV_W'(1);
            if (state == START && bitDone) begin
                state     <= DATA;
                bitCount  <= '0;
                serialOut <= shiftReg[0];
            end else if (state == DATA && bitDone) begin
                shiftReg <= shiftReg >> 1;
                if (bitCount == BIT_W'(DATA_W - 1)) begin
                    state     <= STOP;
                    bitCount  <= '0;
                    serialOut <= 1'b1;
                end else begin
                    bitCount  <= bitCount + BIT_W'(1);
                    serialOut <= shiftReg[1];
                end
            end else if (state == STOP && bitDone) begin
                state     <= stopDone ? IDLE : STOP;
                bitCount  <= stopDone ? '0 : bitCount + BIT_W'(1);
                serialOut <= 1'b1;
            end
        end
    end
endmodule
